// File: rtl/shift_pkg.sv
// Shared constants for the iterative MIPS right shifter (shift_right_seq).
// State encoding, operation encoding and the data/shift-amount widths.
package shift_pkg;

   localparam int WIDTH   = 32;
   localparam int SHAMT_W = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic OP_SRL = 1'b0;
   localparam logic OP_SRA = 1'b1;

endpackage : shift_pkg

// File: rtl/shift_step.sv
// One iteration of the right shifter: shifts data right by 1 or 4 bits,
// filling the vacated upper bits with 'fill'. Purely combinational.
module shift_step
   import shift_pkg::*;
(
   input  logic [WIDTH-1:0] data,
   input  logic             fill,
   input  logic             step4,
   output logic [WIDTH-1:0] result
);

   // select the 4-bit or 1-bit shifted version of the operand
   always_comb begin
      if (step4) begin
         result = {{4{fill}}, data[WIDTH-1:4]};
      end else begin
         result = {fill, data[WIDTH-1:1]};
      end
   end

endmodule : shift_step

// File: rtl/shift_right_seq.sv
// Iterative 32-bit right shifter (srl/sra/srlv/srav) with start/busy/done
// handshake. Shifts 1 bit per cycle; when SHIFT_MULTI_EN is defined it
// shifts 4 bits per cycle while at least 4 remain, giving identical results
// with shorter latency.
module shift_right_seq
   import shift_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               arith,
   input  logic [WIDTH-1:0]   in,
   input  logic [SHAMT_W-1:0] shamt,
   output logic [WIDTH-1:0]   out,
   output logic               busy,
   output logic               done
);

   logic [1:0]         state, state_nxt;
   logic [SHAMT_W-1:0] cnt;
   logic [SHAMT_W-1:0] cnt_dec;
   logic               fill;
   logic               step4;
   logic [WIDTH-1:0]   shifted;

`ifdef SHIFT_MULTI_EN
   assign step4 = (cnt >= SHAMT_W'(4));
`else
   assign step4 = 1'b0;
`endif

   assign cnt_dec = cnt - (step4 ? SHAMT_W'(4) : SHAMT_W'(1));

   shift_step u_step (
      .data   (out),
      .fill   (fill),
      .step4  (step4),
      .result (shifted)
   );

   // state register
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state logic: accept start only in IDLE, leave SHIFT when the count runs out
   // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = (shamt == '0) ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (cnt_dec == '0) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // datapath: load operand on accepted start, shift and count down in SHIFT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out  <= '0;
         cnt  <= '0;
         fill <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  out  <= in;
                  cnt  <= shamt;
                  fill <= (arith == OP_SRA) & in[WIDTH-1];
               end
            end
            S_SHIFT: begin
               out <= shifted;
               cnt <= cnt_dec;
            end
            default: ;
         endcase
      end
   end

   // outputs are pure decodes of the registered state
   always_comb begin
      busy = (state == S_SHIFT) || (state == S_DONE);
      done = (state == S_DONE);
   end

endmodule : shift_right_seq

// File: tb/tb_shift_right_seq.sv
// Self-checking bench for shift_right_seq: stimulus pushes expected results
// into a scoreboard queue; a monitor pops and compares on every done pulse.
module tb_shift_right_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        arith = 1'b0;
   logic [31:0] din = '0;
   logic [4:0]  shamt = '0;
   logic [31:0] dout;
   logic        busy;
   logic        done;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int bcnt = 0;
   logic [31:0] last_exp = '0;

   typedef struct {
      logic [31:0] val;
      int          due;
      int          steps;
   } exp_t;

   exp_t exp_q[$];

   shift_right_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .arith (arith),
      .in    (din),
      .shamt (shamt),
      .out   (dout),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // reference: plain shift operators on the whole word
   function automatic logic [31:0] ref_shift(input logic [31:0] v, input int sa, input logic a);
      logic signed [31:0] s;
      s = v;
      return a ? logic'(1) ? 32'(s >>> sa) : 32'(v >> sa) : 32'(v >> sa);
   endfunction

   // number of clock edges spent in shifting after the start edge
   function automatic int ref_steps(input int sa);
`ifdef SHIFT_MULTI_EN
      return sa / 4 + sa % 4;
`else
      return sa;
`endif
   endfunction

   // monitor: compare every done pulse against the scoreboard head
   always @(negedge clk) begin
      exp_t e;
      if (busy) bcnt = bcnt + 1;
      else bcnt = 0;
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("result", dout, e.val);
            check("done_cycle", 32'(cyc), 32'(e.due));
            check("busy_cycles", 32'(bcnt), 32'(e.steps + 1));
         end
      end
   end

   task automatic run_op(input logic [31:0] v, input int sa, input logic a, input bit push);
      exp_t e;
      @(negedge clk);
      din = v; shamt = 5'(sa); arith = a; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      din = $urandom; shamt = 5'($urandom); arith = 1'($urandom);
      if (push) begin
         e.val   = ref_shift(v, sa, a);
         e.steps = ref_steps(sa);
         e.due   = cyc + e.steps;
         last_exp = e.val;
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("idle_timeout", 32'(busy), 32'd0);
      @(negedge clk);
      check("out_held", dout, last_exp);
   endtask

   task automatic op(input logic [31:0] v, input int sa, input logic a);
      run_op(v, sa, a, 1'b1);
      wait_idle();
   endtask

   initial begin
      #2;
      check("rst_out", dout, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);

      // directed cases
      op(32'h8000_0000, 4, 1'b0);
      check("t1_val", last_exp, 32'h0800_0000);
      op(32'h8000_0000, 4, 1'b1);
      check("t2_val", last_exp, 32'hF800_0000);
      op(32'h1234_5678, 0, 1'b0);
      op(32'h8000_0000, 31, 1'b1);
      check("t4a_val", last_exp, 32'hFFFF_FFFF);
      op(32'h8000_0000, 31, 1'b0);
      check("t4b_val", last_exp, 32'h0000_0001);
      op(32'h8000_0000, 9, 1'b0);
      op(32'h7FFF_FFFF, 31, 1'b1);

      // start while busy must be ignored
      run_op(32'hA5A5_0F0F, 8, 1'b1, 1'b1);
      repeat (2) @(negedge clk);
      din = 32'hFFFF_FFFF; shamt = 5'd1; arith = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);
      check("no_extra_done_q", 32'(exp_q.size()), 32'd0);

      // reset mid-operation aborts without a done pulse
      run_op(32'hDEAD_BEEF, 10, 1'b1, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_out", dout, 32'd0);
      last_exp = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_out", dout, 32'd0);
      op(32'hC000_1234, 5, 1'b1);

      // randomized operations
      for (int i = 0; i < 40; i++) begin
         op($urandom, int'($urandom_range(0, 31)), 1'($urandom));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_shift_right_seq
